instr_fetch_unit: RTL and testbench

Fetch stage of the 5-stage pipeline: owns the program counter, drives the address into the instruction memory, captures the returned instruction and produces the IF/ID pipeline register. It handles decode back-pressure (stall), execute-stage redirects (branch/jump flush) and a halt instruction. It sits between the instruction memory (combinational read) and the decode stage.

---
 rtl/instr_fetch_unit_pkg.sv | 33 +++
 rtl/instr_fetch_unit_if.sv | 33 +++
 rtl/instr_fetch_unit_fetch_pc_reg.sv | 40 ++++
 rtl/instr_fetch_unit.sv | 121 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: state enum, PC constants, IF/ID record and
// next-PC select codes used by instr_fetch_unit and fetch_pc_reg.
package instr_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INCR     = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus;
  } ifid_t;

  // Redirect targets are always word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, decode/execute control and the
// IF/ID register outputs. master = fetch unit, slave = surrounding pipeline.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  // Control semantics: stall_i and redirect_valid_i are level signals sampled
  // on every rising edge; redirect_valid_i wins over stall_i. There is no
  // ready back-channel: the IF/ID register is consumed whenever stall_i is low.
  logic [31:0]  imem_addr;
  logic [31:0]  imem_rdata;
  logic         stall_i;
  logic         redirect_valid_i;
  logic [31:0]  redirect_pc_i;
  logic         ifid_valid;
  logic [31:0]  ifid_instr;
  logic [31:0]  ifid_pc;
  logic [31:0]  ifid_pc_plus;
  logic         halted_o;
  fetch_state_e fetch_state;

  modport master (
    output imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus,
           halted_o, fetch_state,
    input  imem_rdata, stall_i, redirect_valid_i, redirect_pc_i
  );

  modport slave (
    input  imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus,
           halted_o, fetch_state,
    output imem_rdata, stall_i, redirect_valid_i, redirect_pc_i
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_pc_reg.sv
// Program counter register with its next-PC mux (hold / increment / redirect).
module fetch_pc_reg
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  pc_sel_e     sel,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Modulo-2^32 increment: the top word wraps to address 0.
  assign pc_plus = pc_q + PC_STEP;

  always_comb begin
    pc_d = pc_q;
    case (sel)
      PC_INCR:     pc_d = pc_plus;
      PC_REDIRECT: pc_d = align_pc(redirect_pc);
      default:     pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, instruction memory address, IF/ID register, stall/redirect/halt.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = RESET_PC
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_bubbles
`endif
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  ifid_t        ifid_q;
  ifid_t        ifid_d;
  pc_sel_e      pc_sel;
  logic [31:0]  pc;
  logic [31:0]  pc_plus;
  logic         fetch_event;
  logic         bubble_event;

  fetch_pc_reg #(
    .RESET_ADDR (RESET_ADDR)
  ) u_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .sel         (pc_sel),
    .redirect_pc (bus.redirect_pc_i),
    .pc          (pc),
    .pc_plus     (pc_plus)
  );

  always_comb begin
    state_d      = state_q;
    ifid_d       = ifid_q;
    pc_sel       = PC_HOLD;
    fetch_event  = 1'b0;
    bubble_event = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        if (bus.redirect_valid_i) begin
          pc_sel = PC_REDIRECT;
        end
      end
      ST_RUN: begin
        if (bus.redirect_valid_i) begin
          pc_sel       = PC_REDIRECT;
          ifid_d.valid = 1'b0;
          bubble_event = 1'b1;
        end else if (bus.stall_i) begin
          bubble_event = 1'b1;
        end else begin
          ifid_d.valid   = 1'b1;
          ifid_d.instr   = bus.imem_rdata;
          ifid_d.pc      = pc;
          ifid_d.pc_plus = pc_plus;
          fetch_event    = 1'b1;
          // The halt word is delivered to decode but the PC stays on it.
          if (bus.imem_rdata == HALT_INSTR) begin
            state_d = ST_HALT;
          end else begin
            pc_sel = PC_INCR;
          end
        end
      end
      ST_HALT: begin
        if (bus.redirect_valid_i) begin
          pc_sel       = PC_REDIRECT;
          ifid_d.valid = 1'b0;
          state_d      = ST_RUN;
        end else if (!bus.stall_i) begin
          ifid_d.valid = 1'b0;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      ifid_q  <= '0;
    end else begin
      state_q <= state_d;
      ifid_q  <= ifid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (fetch_event) perf_fetched <= perf_fetched + 32'd1;
      if (bubble_event) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`else
  logic unused_events;
  assign unused_events = fetch_event ^ bubble_event;
`endif

  assign bus.imem_addr    = pc;
  assign bus.ifid_valid   = ifid_q.valid;
  assign bus.ifid_instr   = ifid_q.instr;
  assign bus.ifid_pc      = ifid_q.pc;
  assign bus.ifid_pc_plus = ifid_q.pc_plus;
  assign bus.halted_o     = (state_q == ST_HALT);
  assign bus.fetch_state  = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: spec-level fetch model checked every cycle plus
// directed literal checks, and a second instance with a wrapping reset PC.
module tb_instr_fetch_unit;

  localparam logic [31:0] HALT_ADDR = 32'h0000_0020;
  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  instr_fetch_unit_if bus_a ();
  instr_fetch_unit_if bus_b ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_a, perf_bubbles_a;
  logic [31:0] perf_fetched_b, perf_bubbles_b;
`endif

  instr_fetch_unit dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.master)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched_a),
    .perf_bubbles (perf_bubbles_a)
`endif
  );

  instr_fetch_unit #(
    .RESET_ADDR (32'hFFFF_FFF8)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.master)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched_b),
    .perf_bubbles (perf_bubbles_b)
`endif
  );

  // Instruction memory: each word holds its own address, except the halt slot.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr == HALT_ADDR) ? 32'hFFFF_FFFF : addr;
  endfunction

  always_comb bus_a.imem_rdata = mem_word(bus_a.imem_addr);
  assign bus_b.imem_rdata       = bus_b.imem_addr;
  assign bus_b.stall_i          = 1'b0;
  assign bus_b.redirect_valid_i = 1'b0;
  assign bus_b.redirect_pc_i    = 32'h0;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of fetch for dut_a.
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc_plus, m_fetched, m_bubbles;
  logic        m_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= M_BOOT; m_pc <= 32'h0; m_valid <= 1'b0;
      m_instr <= 32'h0; m_ipc <= 32'h0; m_ipc_plus <= 32'h0;
      m_fetched <= 32'h0; m_bubbles <= 32'h0;
    end else if (m_mode == M_BOOT) begin
      m_mode <= M_RUN;
      if (bus_a.redirect_valid_i) m_pc <= bus_a.redirect_pc_i & ~32'h3;
    end else if (m_mode == M_RUN) begin
      if (bus_a.redirect_valid_i) begin
        m_pc <= bus_a.redirect_pc_i & ~32'h3;
        m_valid <= 1'b0;
        m_bubbles <= m_bubbles + 1;
      end else if (bus_a.stall_i) begin
        m_bubbles <= m_bubbles + 1;
      end else begin
        m_valid <= 1'b1;
        m_instr <= mem_word(m_pc);
        m_ipc <= m_pc;
        m_ipc_plus <= m_pc + 4;
        m_fetched <= m_fetched + 1;
        if (mem_word(m_pc) == 32'hFFFF_FFFF) m_mode <= M_HALT;
        else m_pc <= m_pc + 4;
      end
    end else begin
      if (bus_a.redirect_valid_i) begin
        m_pc <= bus_a.redirect_pc_i & ~32'h3;
        m_valid <= 1'b0;
        m_mode <= M_RUN;
      end else if (!bus_a.stall_i) begin
        m_valid <= 1'b0;
      end
    end
  end

  // scoreboard compare process
  always @(negedge clk) begin
    chk("m_imem_addr", bus_a.imem_addr, m_pc);
    chk("m_ifid_valid", {31'b0, bus_a.ifid_valid}, {31'b0, m_valid});
    chk("m_ifid_instr", bus_a.ifid_instr, m_instr);
    chk("m_ifid_pc", bus_a.ifid_pc, m_ipc);
    chk("m_ifid_pc_plus", bus_a.ifid_pc_plus, m_ipc_plus);
    chk("m_halted", {31'b0, bus_a.halted_o}, {31'b0, m_mode == M_HALT});
`ifdef FETCH_PERF_CNT_EN
    chk("m_perf_fetched", perf_fetched_a, m_fetched);
    chk("m_perf_bubbles", perf_bubbles_a, m_bubbles);
`endif
  end

  // driver tasks
  task automatic drive(input logic stall, input logic redir, input logic [31:0] tgt);
    bus_a.stall_i = stall;
    bus_a.redirect_valid_i = redir;
    bus_a.redirect_pc_i = tgt;
  endtask

  task automatic edge_step();
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] st_pat;
    logic [15:0] rd_pat;
    st_pat = 16'b0010_1100_0110_0100;
    rd_pat = 16'b0100_0000_1000_0001;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    repeat (2) edge_step();
    chk("rst_addr", bus_a.imem_addr, 32'h0);
    chk("rst_valid", {31'b0, bus_a.ifid_valid}, 32'h0);
    chk("rst_halted", {31'b0, bus_a.halted_o}, 32'h0);
    chk("rst_b_addr", bus_b.imem_addr, 32'hFFFF_FFF8);
    rst_n = 1'b1;

    edge_step();  // edge 1: BOOT -> RUN
    chk("boot_valid", {31'b0, bus_a.ifid_valid}, 32'h0);
    chk("boot_addr", bus_a.imem_addr, 32'h0);
    edge_step();  // edge 2
    chk("e2_pc", bus_a.ifid_pc, 32'h0);
    chk("e2_pc_plus", bus_a.ifid_pc_plus, 32'h4);
    chk("e2_valid", {31'b0, bus_a.ifid_valid}, 32'h1);
    chk("b_e2_pc", bus_b.ifid_pc, 32'hFFFF_FFF8);
    edge_step();  // edge 3
    chk("e3_pc", bus_a.ifid_pc, 32'h4);
    chk("e3_addr", bus_a.imem_addr, 32'h8);
    chk("b_e3_pc", bus_b.ifid_pc, 32'hFFFF_FFFC);
    chk("b_e3_pc_plus", bus_b.ifid_pc_plus, 32'h0);

    drive(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      edge_step();
      chk("stall_addr", bus_a.imem_addr, 32'h8);
      chk("stall_pc", bus_a.ifid_pc, 32'h4);
      if (i == 0) chk("b_e4_pc", bus_b.ifid_pc, 32'h0);
    end
    drive(1'b0, 1'b0, 32'h0);
    edge_step();
    chk("resume_pc", bus_a.ifid_pc, 32'h8);
    chk("resume_addr", bus_a.imem_addr, 32'hC);

    drive(1'b1, 1'b1, 32'h103);  // redirect wins over stall
    edge_step();
    chk("redir_valid", {31'b0, bus_a.ifid_valid}, 32'h0);
    chk("redir_addr", bus_a.imem_addr, 32'h100);
    drive(1'b0, 1'b0, 32'h0);
    edge_step();
    chk("redir_pc", bus_a.ifid_pc, 32'h100);
    chk("redir_valid2", {31'b0, bus_a.ifid_valid}, 32'h1);

    drive(1'b0, 1'b1, 32'h18);
    edge_step();
    drive(1'b0, 1'b0, 32'h0);
    repeat (3) edge_step();  // captures 0x18, 0x1C, then halt word at 0x20
    chk("halt_pc", bus_a.ifid_pc, 32'h20);
    chk("halt_instr", bus_a.ifid_instr, 32'hFFFF_FFFF);
    chk("halt_valid", {31'b0, bus_a.ifid_valid}, 32'h1);
    chk("halt_flag", {31'b0, bus_a.halted_o}, 32'h1);
    edge_step();
    chk("halt_bubble", {31'b0, bus_a.ifid_valid}, 32'h0);
    chk("halt_addr", bus_a.imem_addr, 32'h20);
    drive(1'b1, 1'b0, 32'h0);
    edge_step();
    chk("halt_stall_addr", bus_a.imem_addr, 32'h20);
    drive(1'b0, 1'b1, 32'h40);
    edge_step();
    chk("unhalt_flag", {31'b0, bus_a.halted_o}, 32'h0);
    chk("unhalt_addr", bus_a.imem_addr, 32'h40);
    drive(1'b0, 1'b0, 32'h0);
    edge_step();
    chk("unhalt_pc", bus_a.ifid_pc, 32'h40);

    for (int i = 0; i < 16; i++) begin
      drive(st_pat[i], rd_pat[i], 32'h200 + 32'(i * 8) + 32'h3);
      edge_step();
    end

    drive(1'b0, 1'b1, 32'h80);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", bus_a.imem_addr, 32'h0);
    chk("mid_rst_valid", {31'b0, bus_a.ifid_valid}, 32'h0);
    chk("mid_rst_instr", bus_a.ifid_instr, 32'h0);
    chk("mid_rst_pc", bus_a.ifid_pc, 32'h0);
    chk("mid_rst_pc_plus", bus_a.ifid_pc_plus, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("mid_rst_perf_f", perf_fetched_a, 32'h0);
    chk("mid_rst_perf_b", perf_bubbles_a, 32'h0);
`endif
    edge_step();
    drive(1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    repeat (2) edge_step();
    chk("rerun_pc", bus_a.ifid_pc, 32'h0);
    chk("rerun_valid", {31'b0, bus_a.ifid_valid}, 32'h1);
    repeat (2) edge_step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
